// File: rtl/mult_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mult_display_ctrl
// Description : Sequencer for the signed-multiply display path: operand
//               capture, multiplier handshake with timeout, BCD load, scroll.
// Revision    : 1.0 - initial release
// ============================================================================

module mult_display_ctrl #(
  parameter int WIDTH   = 8,
  parameter int DIGITS  = 5,
  parameter int WINDOW  = 4,
  parameter int TIMEOUT = 64,
  localparam int POS_W  = $clog2(DIGITS - WINDOW + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               go,
  input  logic               scroll_left,
  input  logic               scroll_right,
  input  logic [WIDTH-1:0]   num1,
  input  logic [WIDTH-1:0]   num2,
  input  logic               mult_done,
  input  logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   op_a,
  output logic [WIDTH-1:0]   op_b,
  output logic               mult_rst,
  output logic               mult_start,
  output logic               sr_load,
  output logic               sr_en,
  output logic               sr_dir,
  output logic               sign,
  output logic [POS_W-1:0]   pos,
  output logic               busy,
  output logic               err
);

  localparam int               CNT_W      = $clog2(TIMEOUT);
  localparam logic [POS_W-1:0] c_max_pos  = POS_W'(DIGITS - WINDOW);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CAPTURE, S_START, S_WAIT_DONE,
    S_CONVERT, S_LOAD_SR, S_SHOW, S_ERROR
  } state_t;

  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             r_sign_raw;
  logic             w_scroll_l, w_scroll_r;
  logic [WIDTH-1:0] w_mag_a, w_mag_b;

  // Two's-complement negate; the most negative value wraps onto its unsigned magnitude.
  assign w_mag_a   = num1[WIDTH-1] ? (~num1 + WIDTH'(1)) : num1;
  assign w_mag_b   = num2[WIDTH-1] ? (~num2 + WIDTH'(1)) : num2;
  assign w_cnt_inc = r_cnt + CNT_W'(1);

  always_comb begin
    w_scroll_l = 1'b0;
    w_scroll_r = 1'b0;
    if (r_state == S_SHOW && !go && (scroll_left ^ scroll_right)) begin
      w_scroll_l = scroll_left  && (pos < c_max_pos);
      w_scroll_r = scroll_right && (pos != '0);
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (go) w_next = S_CAPTURE;
      S_CAPTURE:   w_next = S_START;
      S_START:     w_next = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (mult_done)                    w_next = S_CONVERT;
        else if (w_cnt_inc == c_cnt_last) w_next = S_ERROR;
      end
      S_CONVERT:   w_next = S_LOAD_SR;
      S_LOAD_SR:   w_next = S_SHOW;
      S_SHOW:      if (go) w_next = S_CAPTURE;
      S_ERROR:     if (go) w_next = S_CAPTURE;
      default:     w_next = S_IDLE;
    endcase
  end

  assign mult_rst   = (r_state == S_CAPTURE);
  assign mult_start = (r_state == S_START) || (r_state == S_WAIT_DONE);
  assign sr_load    = (r_state == S_LOAD_SR);
  assign sr_en      = w_scroll_l | w_scroll_r;
  assign sr_dir     = w_scroll_r;
  assign busy       = !((r_state == S_IDLE) || (r_state == S_SHOW) || (r_state == S_ERROR));
  assign err        = (r_state == S_ERROR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_sign_raw <= 1'b0;
      op_a       <= '0;
      op_b       <= '0;
      sign       <= 1'b0;
      pos        <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_CAPTURE: begin
          op_a       <= w_mag_a;
          op_b       <= w_mag_b;
          r_sign_raw <= num1[WIDTH-1] ^ num2[WIDTH-1];
          pos        <= '0;
        end
        S_START:     r_cnt <= '0;
        S_WAIT_DONE: r_cnt <= w_cnt_inc;
        // A zero product is never shown as negative.
        S_CONVERT:   sign  <= r_sign_raw & (|product);
        S_SHOW: begin
          if (w_scroll_l)      pos <= pos + POS_W'(1);
          else if (w_scroll_r) pos <= pos - POS_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mult_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_display_ctrl
// Description : Self-checking bench; a transaction timeline model predicts
//               every output on every cycle.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_mult_display_ctrl;

  localparam int WIDTH   = 8;
  localparam int DIGITS  = 5;
  localparam int WINDOW  = 4;
  localparam int TIMEOUT = 64;
  localparam int POS_W   = $clog2(DIGITS - WINDOW + 1);

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               go = 1'b0, scroll_left = 1'b0, scroll_right = 1'b0, mult_done = 1'b0;
  logic [WIDTH-1:0]   num1 = '0, num2 = '0;
  logic [2*WIDTH-1:0] product = '0;
  logic [WIDTH-1:0]   op_a, op_b;
  logic               mult_rst, mult_start, sr_load, sr_en, sr_dir, sign, busy, err;
  logic [POS_W-1:0]   pos;

  mult_display_ctrl #(.WIDTH(WIDTH), .DIGITS(DIGITS), .WINDOW(WINDOW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .go(go), .scroll_left(scroll_left), .scroll_right(scroll_right),
    .num1(num1), .num2(num2), .mult_done(mult_done), .product(product),
    .op_a(op_a), .op_b(op_b), .mult_rst(mult_rst), .mult_start(mult_start),
    .sr_load(sr_load), .sr_en(sr_en), .sr_dir(sr_dir), .sign(sign), .pos(pos),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  int start_cycles = 0;
  bit check_en = 1'b0;

  // Model state: values the display path should be holding.
  logic [WIDTH-1:0] m_op_a = '0, m_op_b = '0;
  bit               m_sign = 1'b0;
  int               m_pos = 0;
  bit               q_err = 1'b0;

  bit               e_rst, e_start, e_load, e_en, e_dir, e_busy, e_err, e_sign;
  logic [WIDTH-1:0] e_op_a, e_op_b;
  int               e_pos;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    int s;
    s = $signed(v);
    if (s < 0) s = -s;
    return WIDTH'(s);
  endfunction

  task automatic set_exp(input bit r, input bit s, input bit l, input bit en,
                         input bit dir, input bit b, input bit e);
    e_rst = r; e_start = s; e_load = l; e_en = en; e_dir = dir; e_busy = b; e_err = e;
    e_op_a = m_op_a; e_op_b = m_op_b; e_sign = m_sign; e_pos = m_pos;
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      if (mult_start === 1'b1) start_cycles++;
      chk("op_a", op_a, e_op_a);
      chk("op_b", op_b, e_op_b);
      chk("mult_rst", mult_rst, e_rst);
      chk("mult_start", mult_start, e_start);
      chk("sr_load", sr_load, e_load);
      chk("sr_en", sr_en, e_en);
      chk("sr_dir", sr_dir, e_dir);
      chk("sign", sign, e_sign);
      chk("pos", pos, e_pos);
      chk("busy", busy, e_busy);
      chk("err", err, e_err);
    end
  end

  task automatic step();
    @(posedge clk); #1;
    go = 1'b0; scroll_left = 1'b0; scroll_right = 1'b0; mult_done = 1'b0;
  endtask

  // Requests that the sequencer must ignore while busy.
  task automatic noise();
    go           = ($urandom_range(0, 3) == 0);
    scroll_left  = 1'($urandom_range(0, 1));
    scroll_right = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      set_exp(0, 0, 0, 0, 0, 0, q_err);
    end
  endtask

  task automatic do_reset();
    check_en = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("rst_op_a", op_a, 0);      chk("rst_op_b", op_b, 0);
    chk("rst_mult_rst", mult_rst, 0); chk("rst_mult_start", mult_start, 0);
    chk("rst_sr_load", sr_load, 0); chk("rst_sr_en", sr_en, 0);
    chk("rst_sr_dir", sr_dir, 0);   chk("rst_sign", sign, 0);
    chk("rst_pos", pos, 0);         chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    m_op_a = '0; m_op_b = '0; m_sign = 1'b0; m_pos = 0; q_err = 1'b0;
    go = 1'b0; scroll_left = 1'b0; scroll_right = 1'b0; mult_done = 1'b0;
    @(posedge clk); #1;
    chk("rst_hold_busy", busy, 0);
    chk("rst_hold_start", mult_start, 0);
    #1 rst = 1'b1;
    set_exp(0, 0, 0, 0, 0, 0, 0);
    check_en = 1'b1;
  endtask

  // status: 0 = result shown, 1 = timed out, 2 = aborted by reset.
  // d = cycles after START at which mult_done is presented.
  task automatic run_mult(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int d,
                          input logic [2*WIDTH-1:0] prod, input int abort_k, output int status);
    bit sraw;
    step(); noise(); go = 1'b1; num1 = a; num2 = b;
    set_exp(0, 0, 0, 0, 0, 0, q_err);
    step(); noise();
    set_exp(1, 0, 0, 0, 0, 1, 0);
    step(); noise();
    m_op_a = mag(a); m_op_b = mag(b); m_pos = 0;
    sraw = a[WIDTH-1] ^ b[WIDTH-1];
    num1 = WIDTH'($urandom); num2 = WIDTH'($urandom);
    set_exp(0, 1, 0, 0, 0, 1, 0);
    for (int k = 1; k < TIMEOUT; k++) begin
      step(); noise();
      mult_done = (k == d);
      set_exp(0, 1, 0, 0, 0, 1, 0);
      if (k == abort_k) begin
        do_reset();
        status = 2;
        return;
      end
      if (k == d) break;
    end
    if (d < 1 || d >= TIMEOUT) begin
      step();
      set_exp(0, 0, 0, 0, 0, 0, 1);
      q_err = 1'b1;
      status = 1;
      return;
    end
    step(); noise(); product = prod;
    set_exp(0, 0, 0, 0, 0, 1, 0);
    step(); noise();
    m_sign = sraw && (prod != '0);
    product = (2*WIDTH)'($urandom);
    set_exp(0, 0, 1, 0, 0, 1, 0);
    step();
    set_exp(0, 0, 0, 0, 0, 0, 0);
    q_err = 1'b0;
    status = 0;
  endtask

  task automatic scroll_cycle(input bit l, input bit r);
    bit en, dir;
    step(); scroll_left = l; scroll_right = r;
    en = 1'b0; dir = 1'b0;
    if (l && !r && m_pos < DIGITS - WINDOW) en = 1'b1;
    else if (r && !l && m_pos > 0) begin en = 1'b1; dir = 1'b1; end
    set_exp(0, 0, 0, en, dir, 0, 0);
    if (en) m_pos += dir ? -1 : 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    set_exp(0, 0, 0, 0, 0, 0, 0);
    check_en = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    idle(2);

    start_cycles = 0;
    run_mult(-8'sd5, 8'sd10, 8, 16'd50, 0, st);
    chk("t1_status", st, 0);
    chk("t1_start_len", start_cycles, 9);
    chk("pin_op_a_5", op_a, 5);
    chk("pin_op_b_10", op_b, 10);
    chk("pin_sign_neg", sign, 1);
    chk("pin_busy_show", busy, 0);

    repeat (3) scroll_cycle(1, 0);
    idle(1);
    chk("pin_pos_left", pos, 1);
    repeat (2) scroll_cycle(0, 1);
    scroll_cycle(1, 1);
    scroll_cycle(1, 0);
    scroll_cycle(1, 1);
    idle(1);
    chk("pin_pos_after", pos, 1);

    run_mult(8'd0, -8'sd3, 3, 16'd0, 0, st);
    chk("pin_zero_sign", sign, 0);
    run_mult(8'h80, 8'hFF, 5, 16'd128, 0, st);
    chk("pin_op_a_128", op_a, 128);
    chk("pin_op_b_1", op_b, 1);
    chk("pin_sign_pos", sign, 0);

    run_mult(8'd7, 8'd9, TIMEOUT + 10, 16'd63, 0, st);
    chk("t_timeout_status", st, 1);
    chk("pin_err", err, 1);
    idle(2);
    run_mult(8'd2, -8'sd2, TIMEOUT - 1, 16'd4, 0, st);
    chk("t_boundary_status", st, 0);
    chk("pin_boundary_sign", sign, 1);

    run_mult(8'd3, 8'd4, 50, 16'd12, 5, st);
    chk("t_abort_status", st, 2);
    idle(2);
    run_mult(8'd6, -8'sd7, 2, 16'd42, 0, st);
    chk("t_after_reset", st, 0);

    for (int i = 0; i < 30; i++) begin
      logic [WIDTH-1:0]   a, b;
      logic [2*WIDTH-1:0] p;
      int d;
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
      if (i % 5 == 0) a = '0;
      if (i % 7 == 3) b = 8'h80;
      d = (i % 9 == 4) ? TIMEOUT + 1 : $urandom_range(1, 12);
      p = {{WIDTH{1'b0}}, mag(a)} * {{WIDTH{1'b0}}, mag(b)};
      run_mult(a, b, d, p, 0, st);
      if (st == 0) begin
        for (int j = 0; j < $urandom_range(2, 6); j++)
          scroll_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else begin
        idle(2);
      end
    end

    idle(2);
    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mult_display_ctrl.md
Name: mult_display_ctrl

Overview:
Top-level sequencer for the signed-multiply display path. Captures two signed operands on a `go` pulse, drives the sequential multiplier, and waits one cycle for the BCD converter to settle. It then loads the bidirectional BCD shift register and services scroll-left/scroll-right requests within digit bounds. It also owns the result sign flag, a multiplier timeout and the busy/error status.

Parameters:
- WIDTH, 8, operand width (signed two's complement in, unsigned magnitude out)
- DIGITS, 5, BCD digits held in the shift register
- WINDOW, 4, digits visible on the display
- TIMEOUT, 64, max cycles waiting for mult_done before error

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- go  in  1  single-cycle start pulse (debounced upstream)
- scroll_left  in  1  single-cycle scroll request
- scroll_right  in  1  single-cycle scroll request
- num1  in  WIDTH  signed operand A
- num2  in  WIDTH  signed operand B
- mult_done  in  1  multiplier done level
- product  in  2*WIDTH  multiplier product (used for zero detect)
- op_a  out  WIDTH  registered magnitude of num1
- op_b  out  WIDTH  registered magnitude of num2
- mult_rst  out  1  active-high clear to multiplier
- mult_start  out  1  multiplier start level
- sr_load  out  1  shift-register parallel load
- sr_en  out  1  shift-register shift enable
- sr_dir  out  1  shift direction: 0 = left, 1 = right
- sign  out  1  result negative flag
- pos  out  $clog2(DIGITS-WINDOW+1)  current scroll offset
- busy  out  1  high in every state except IDLE/SHOW/ERROR
- err  out  1  timeout flag

Behaviour:
- Reset (rst = 0, async): state IDLE; all outputs 0; timeout counter 0.
- States: IDLE, CAPTURE, START, WAIT_DONE, CONVERT, LOAD_SR, SHOW, ERROR.
- IDLE: on go, go to CAPTURE.
- CAPTURE (1 cycle): register op_a = |num1| and op_b = |num2|.
  - -2^(WIDTH-1) maps to 2^(WIDTH-1), which fits unsigned.
  - sign_raw = num1[MSB] ^ num2[MSB].
  - mult_rst = 1 this cycle only; pos cleared to 0. Next state: START.
- START (1 cycle): mult_start = 1; timeout counter cleared. Next state: WAIT_DONE.
- WAIT_DONE: mult_start stays 1; counter increments each cycle.
  - If mult_done = 1: drop mult_start, go to CONVERT.
  - Else if counter reaches TIMEOUT-1: go to ERROR.
  - mult_done wins if both conditions occur in the same cycle.
- CONVERT (1 cycle): settle cycle for the combinational BCD converter.
  - sign = sign_raw & (product != 0); a zero result is never negative.
- LOAD_SR (1 cycle): sr_load = 1; next state: SHOW.
- SHOW: busy = 0. Requests are handled in priority order:
  - go: restart at CAPTURE; scroll requests ignored that cycle.
  - scroll_left and scroll_right both high: ignored.
  - scroll_left with pos < DIGITS-WINDOW: sr_en = 1, sr_dir = 0 for exactly one cycle; pos + 1.
  - scroll_right with pos > 0: sr_en = 1, sr_dir = 1 for one cycle; pos - 1.
  - Out-of-bound requests: ignored; no sr_en, pos unchanged.
- ERROR: err = 1; mult_start = 0; op_a, op_b, sign held. go clears err and goes to CAPTURE.
- Latency: go at edge N gives mult_start high from N+2. mult_done seen at edge M gives sr_load high in cycle M+2 and SHOW at M+3.
- sr_load and sr_en are mutually exclusive and never asserted outside LOAD_SR/SHOW.
- go in any busy state is ignored.
- Reset mid-operation aborts immediately; there is no partial load.

Test Plan:
- num1 = -5, num2 = 10, go, mult_done 8 cycles after START -> op_a = 5, op_b = 10, mult_start high exactly 9 cycles, sr_load one cycle 2 cycles after done, sign = 1, busy falls in SHOW.
- num1 = 0, num2 = -3, product = 0 -> sign = 0; num1 = -128, num2 = -1 -> op_a = 128, op_b = 1, sign = 0.
- In SHOW, scroll_left ×3 -> first gives sr_en = 1, sr_dir = 0, pos = 1; the next two give no sr_en, pos stays 1. Then scroll_right ×2 -> one sr_en with sr_dir = 1, pos = 0, second ignored. Simultaneous left+right -> nothing.
- mult_done never asserted -> ERROR entered TIMEOUT cycles after START, err = 1, mult_start = 0. go -> err clears, CAPTURE, mult_rst pulses.
- rst low during WAIT_DONE -> all outputs 0 asynchronously, before the next clock edge. After release, go runs a full sequence normally.
- go pulses during WAIT_DONE and during LOAD_SR -> ignored. go in SHOW with new operands -> pos resets to 0, new result loaded.
